// File: rtl/h_sync_gen.sv
// Horizontal timing generator: counts pixel ticks per line and produces
// active-low h_sync, h_de, the active pixel column and an end-of-line pulse.
module h_sync_gen #(
    parameter int unsigned PULSE_LENGTH = 96,
    parameter int unsigned BACK_PORCH   = 48,
    parameter int unsigned ACTIVE_VIDEO = 640,
    parameter int unsigned FRONT_PORCH  = 16,
    parameter int unsigned CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             h_en,
    output logic             h_sync,
    output logic             h_de,
    output logic [CNT_W-1:0] pixel_col,
    output logic             line_end,
    output logic             h_busy
);

    localparam int unsigned TOTAL = PULSE_LENGTH + BACK_PORCH + ACTIVE_VIDEO + FRONT_PORCH;

    localparam logic [CNT_W-1:0] BP_START = CNT_W'(PULSE_LENGTH);
    localparam logic [CNT_W-1:0] AP_START = CNT_W'(PULSE_LENGTH + BACK_PORCH);
    localparam logic [CNT_W-1:0] FP_START = CNT_W'(PULSE_LENGTH + BACK_PORCH + ACTIVE_VIDEO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        SP   = 5'b00010,
        BP   = 5'b00100,
        AP   = 5'b01000,
        FP   = 5'b10000
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] h_cnt;

    logic [CNT_W-1:0] cnt_inc;
    state_t           inc_state;
    logic             inc_sync;
    logic             inc_de;
    logic [CNT_W-1:0] inc_col;

    // Region and output values for the incremented (non-wrapping) count
    always_comb begin
        cnt_inc   = h_cnt + CNT_W'(1);
        inc_state = SP;
        inc_sync  = 1'b0;
        inc_de    = 1'b0;
        inc_col   = '0;
        if (cnt_inc >= FP_START) begin
            inc_state = FP;
            inc_sync  = 1'b1;
        end else if (cnt_inc >= AP_START) begin
            inc_state = AP;
            inc_sync  = 1'b1;
            inc_de    = 1'b1;
            inc_col   = cnt_inc - AP_START;
        end else if (cnt_inc >= BP_START) begin
            inc_state = BP;
            inc_sync  = 1'b1;
        end
    end

    // Line state machine with registered outputs, advancing only on pixel ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            h_cnt     <= '0;
            h_sync    <= 1'b1;
            h_de      <= 1'b0;
            pixel_col <= '0;
            line_end  <= 1'b0;
            h_busy    <= 1'b0;
        end else begin
            line_end <= 1'b0;
            if (pix_en) begin
                case (state)
                    IDLE: begin
                        if (h_en) begin
                            state     <= SP;
                            h_cnt     <= '0;
                            h_sync    <= 1'b0;
                            h_de      <= 1'b0;
                            pixel_col <= '0;
                            h_busy    <= 1'b1;
                        end
                    end
                    default: begin
                        if (h_cnt == LAST_CNT) begin
                            // h_en is only looked at here, so a line always completes
                            line_end  <= 1'b1;
                            h_cnt     <= '0;
                            h_de      <= 1'b0;
                            pixel_col <= '0;
                            if (h_en) begin
                                state  <= SP;
                                h_sync <= 1'b0;
                                h_busy <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                h_sync <= 1'b1;
                                h_busy <= 1'b0;
                            end
                        end else begin
                            state     <= inc_state;
                            h_cnt     <= cnt_inc;
                            h_sync    <= inc_sync;
                            h_de      <= inc_de;
                            pixel_col <= inc_col;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_h_sync_gen.sv
// Self-checking bench for h_sync_gen against an integer line-position model.
module tb_h_sync_gen;

    localparam int PL  = 96;
    localparam int BPR = 48;
    localparam int AV  = 640;
    localparam int FPR = 16;
    localparam int CW  = 10;
    localparam int TOT = PL + BPR + AV + FPR;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_en = 1'b0;
    logic          h_en = 1'b0;
    logic          h_sync, h_de, line_end, h_busy;
    logic [CW-1:0] pixel_col;
    logic [CW+3:0] obs;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: whether a line is running, position in line, end-of-line pulse
    bit m_run;
    int m_c;
    bit m_le;

    h_sync_gen #(
        .PULSE_LENGTH(PL), .BACK_PORCH(BPR), .ACTIVE_VIDEO(AV),
        .FRONT_PORCH(FPR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h_en(h_en),
        .h_sync(h_sync), .h_de(h_de), .pixel_col(pixel_col),
        .line_end(line_end), .h_busy(h_busy)
    );

    assign obs = {h_sync, h_de, pixel_col, line_end, h_busy};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 1'b0;
            m_c   = 0;
            m_le  = 1'b0;
        end else begin
            m_le = 1'b0;
            if (pix_en) begin
                if (!m_run) begin
                    if (h_en) begin
                        m_run = 1'b1;
                        m_c   = 0;
                    end
                end else if (m_c == TOT - 1) begin
                    m_le  = 1'b1;
                    m_c   = 0;
                    m_run = h_en;
                end else begin
                    m_c = m_c + 1;
                end
            end
        end
    end

    function automatic logic [CW+3:0] exp_vec();
        logic          s, d;
        logic [CW-1:0] col;
        s   = !(m_run && m_c < PL);
        d   = m_run && (m_c >= PL + BPR) && (m_c < PL + BPR + AV);
        col = d ? CW'(m_c - (PL + BPR)) : '0;
        return {s, d, col, m_le, m_run};
    endfunction

    task automatic test_reset();
        rst = 1'b0; h_en = 1'b0; pix_en = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (obs !== 14'b1_0_0000000000_0_0) begin
            fails++; $display("FAIL reset_state got=%b exp=%b", obs, 14'b1_0_0000000000_0_0);
        end
        rst = 1'b1; pix_en = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (h_busy !== 1'b0 || h_sync !== 1'b1) begin
            fails++; $display("FAIL idle_without_h_en got busy=%b sync=%b exp busy=0 sync=1", h_busy, h_sync);
        end
    endtask

    task automatic test_half_rate();
        int  falls[$];
        int  low_clk = 0;
        int  de_clk = 0;
        int  first_de = -1;
        logic prev_s = 1'b1;
        h_en = 1'b1;
        for (int i = 0; i < 4 * 2 * TOT; i++) begin
            pix_en = (i % 2 == 0);
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL half_rate_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
            if (prev_s && !h_sync) falls.push_back(i);
            if (falls.size() == 1) begin
                if (!h_sync) low_clk++;
                if (h_de) begin
                    de_clk++;
                    if (first_de < 0) first_de = i - falls[0];
                end
            end
            prev_s = h_sync;
        end
        tests++;
        if (falls.size() != 4) begin
            fails++; $display("FAIL half_rate_fall_count got=%0d exp=4", falls.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                tests++;
                if (falls[k] - falls[k-1] != 2 * TOT) begin
                    fails++; $display("FAIL half_rate_period got=%0d exp=%0d", falls[k] - falls[k-1], 2 * TOT);
                end
            end
        end
        tests++;
        if (low_clk != 2 * PL) begin
            fails++; $display("FAIL half_rate_sync_width got=%0d exp=%0d", low_clk, 2 * PL);
        end
        tests++;
        if (de_clk != 2 * AV || first_de != 2 * (PL + BPR)) begin
            fails++; $display("FAIL half_rate_de got=%0d@%0d exp=%0d@%0d", de_clk, first_de, 2 * AV, 2 * (PL + BPR));
        end
    endtask

    task automatic test_full_rate();
        int   n;
        int   de_cnt = 0;
        logic prev_de = 1'b0;
        logic [CW-1:0] prev_col = '0;
        pix_en = 1'b1; h_en = 1'b1;
        for (n = 0; n < 3 * TOT && !line_end; n++) @(negedge clk);
        tests++;
        if (!line_end) begin
            fails++; $display("FAIL full_rate_wait_line got=timeout exp=line_end");
        end
        for (n = 0; n < 2 * TOT; n++) begin
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL full_rate_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
            if (line_end) break;
            if (h_de) de_cnt++;
            if (h_de && !prev_de) begin
                tests++;
                if (pixel_col !== '0) begin
                    fails++; $display("FAIL first_col got=%0d exp=0", pixel_col);
                end
            end
            if (!h_de && prev_de) begin
                tests++;
                if (prev_col !== CW'(AV - 1)) begin
                    fails++; $display("FAIL last_col got=%0d exp=%0d", prev_col, AV - 1);
                end
            end
            if (!h_de && pixel_col !== '0) begin
                tests++; fails++;
                $display("FAIL blank_col got=%0d exp=0", pixel_col);
            end
            prev_de  = h_de;
            prev_col = pixel_col;
        end
        tests++;
        if (de_cnt != AV) begin
            fails++; $display("FAIL full_rate_de_count got=%0d exp=%0d", de_cnt, AV);
        end
    endtask

    task automatic test_wrap();
        int   le_cnt = 0;
        logic prev_le = 1'b0;
        logic prev_s = h_sync;
        h_en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            pix_en = ($urandom % 3) != 0;
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL wrap_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
            if (line_end) begin
                le_cnt++;
                tests++;
                if (prev_le || !prev_s || h_sync) begin
                    fails++; $display("FAIL wrap_edge got prev_le=%b prev_s=%b s=%b exp 0,1,0", prev_le, prev_s, h_sync);
                end
            end
            prev_le = line_end;
            prev_s  = h_sync;
        end
        tests++;
        if (le_cnt < 2) begin
            fails++; $display("FAIL wrap_pulse_count got=%0d exp>=2", le_cnt);
        end
    endtask

    task automatic test_drop_h_en();
        int n;
        pix_en = 1'b1; h_en = 1'b1;
        for (n = 0; n < 2 * TOT && !(m_run && m_c == 300); n++) @(negedge clk);
        tests++;
        if (!(m_run && m_c == 300)) begin
            fails++; $display("FAIL drop_wait got=timeout exp=count_300");
        end
        h_en = 1'b0;
        for (n = 0; n < TOT && !line_end; ) begin
            @(negedge clk);
            n++;
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL drop_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        tests++;
        if (n != TOT - 300) begin
            fails++; $display("FAIL drop_ticks_to_end got=%0d exp=%0d", n, TOT - 300);
        end
        tests++;
        if (h_busy !== 1'b0 || h_sync !== 1'b1 || h_de !== 1'b0) begin
            fails++; $display("FAIL drop_idle got busy=%b sync=%b de=%b exp 0,1,0", h_busy, h_sync, h_de);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (h_busy !== 1'b0 || line_end !== 1'b0) begin
            fails++; $display("FAIL drop_stays_idle got busy=%b le=%b exp 0,0", h_busy, line_end);
        end
        h_en = 1'b1;
        @(negedge clk);
        tests++;
        if (h_sync !== 1'b0 || h_busy !== 1'b1 || obs !== exp_vec()) begin
            fails++; $display("FAIL restart got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        pix_en = 1'b1; h_en = 1'b1;
        for (n = 0; n < 2 * TOT && !(m_run && m_c == 500); n++) @(negedge clk);
        tests++;
        if (!(m_run && m_c == 500) || h_de !== 1'b1) begin
            fails++; $display("FAIL rst_mid_wait got de=%b exp=1 at count_500", h_de);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (obs !== 14'b1_0_0000000000_0_0) begin
            fails++; $display("FAIL rst_mid_async got=%b exp=%b", obs, 14'b1_0_0000000000_0_0);
        end
        @(negedge clk);
        h_en = 1'b0; rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            tests++;
            if (h_busy !== 1'b0 || obs !== exp_vec()) begin
                fails++; $display("FAIL rst_mid_idle got=%h exp=%h", obs, exp_vec());
            end
        end
        h_en = 1'b1;
    endtask

    task automatic test_gate();
        int n;
        int t0;
        logic [CW+3:0] snap;
        pix_en = 1'b1; h_en = 1'b1;
        for (n = 0; n < 3 * TOT && !line_end; n++) @(negedge clk);
        t0 = cyc;
        for (n = 0; n < TOT && !(m_run && m_c == 200); n++) @(negedge clk);
        tests++;
        if (!(m_run && m_c == 200)) begin
            fails++; $display("FAIL gate_wait got=timeout exp=count_200");
        end
        snap = obs;
        pix_en = 1'b0;
        repeat (50) begin
            @(negedge clk);
            tests++;
            if (obs !== snap) begin
                fails++; $display("FAIL gate_frozen got=%h exp=%h", obs, snap);
            end
        end
        pix_en = 1'b1;
        for (n = 0; n < 2 * TOT && !line_end; n++) begin
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL gate_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
        tests++;
        if (cyc - t0 != TOT + 50) begin
            fails++; $display("FAIL gate_period got=%0d exp=%0d", cyc - t0, TOT + 50);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pix_en = ($urandom % 4) != 0;
            if ($urandom % 300 == 0) h_en = ~h_en;
            @(negedge clk);
            tests++;
            if (obs !== exp_vec()) begin
                fails++; $display("FAIL random_model t=%0t got=%h exp=%h", $time, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_half_rate();
        test_full_rate();
        test_wrap();
        test_drop_h_en();
        test_reset_mid();
        test_gate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
